// File: rtl/bw_io_ddr_zcal_ctl.sv
// DDR pad impedance calibration controller: successive-approximation search of
// the pull-up then pull-down replica codes, with deferred, atomic update of cbu/cbd.
module bw_io_ddr_zcal_ctl #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter logic [7:0]  RST_CODE   = 8'h80
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       cal_start,
  input  logic       hold_upd,
  input  logic       cmp_pu,
  input  logic       cmp_pd,
  output logic [7:0] trial_pu,
  output logic [7:0] trial_pd,
  output logic [8:1] cbu,
  output logic [8:1] cbd,
  output logic       cal_busy,
  output logic       upd,
  output logic       cal_err
);

  typedef enum logic [1:0] {IDLE, PU_SAR, PD_SAR, PEND} state_e;

  state_e     state_q;
  logic [3:0] settle_q;
  logic [2:0] bit_q;
  logic [7:0] trial_pu_q, trial_pd_q;
  logic [7:0] trial_pu_d, trial_pd_d;
  logic [8:1] cbu_q, cbd_q;
  logic       busy_q, upd_q, err_q;
  logic       sample;

  function automatic logic is_sat(input logic [7:0] code);
    return (code == 8'h00) || (code == 8'hFF);
  endfunction

  assign sample = (settle_q == 4'(SETTLE_CYC));

  // Decided trial codes: current bit takes the comparator, next lower bit becomes the new trial bit.
  always_comb begin
    trial_pu_d = trial_pu_q;
    trial_pd_d = trial_pd_q;
    trial_pu_d[bit_q] = cmp_pu;
    trial_pd_d[bit_q] = cmp_pd;
    if (bit_q != 3'd0) begin
      trial_pu_d[bit_q - 3'd1] = 1'b1;
      trial_pd_d[bit_q - 3'd1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      settle_q   <= 4'd0;
      bit_q      <= 3'd0;
      trial_pu_q <= 8'h00;
      trial_pd_q <= 8'h00;
      cbu_q      <= RST_CODE;
      cbd_q      <= RST_CODE;
      busy_q     <= 1'b0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cal_start) begin
            state_q    <= PU_SAR;
            trial_pu_q <= 8'h80;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            bit_q      <= 3'd7;
            settle_q   <= 4'd0;
          end
        end
        PU_SAR: begin
          if (sample) begin
            settle_q   <= 4'd0;
            trial_pu_q <= trial_pu_d;
            if (bit_q == 3'd0) begin
              state_q    <= PD_SAR;
              trial_pd_q <= 8'h80;
              bit_q      <= 3'd7;
            end else begin
              bit_q <= bit_q - 3'd1;
            end
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        PD_SAR: begin
          if (sample) begin
            settle_q   <= 4'd0;
            trial_pd_q <= trial_pd_d;
            if (bit_q == 3'd0) begin
              // A rail-to-rail result means the replica never balanced; keep the old codes.
              if (is_sat(trial_pu_q) || is_sat(trial_pd_d)) begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else if (!hold_upd) begin
                cbu_q   <= trial_pu_q;
                cbd_q   <= trial_pd_d;
                upd_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                state_q <= PEND;
              end
            end else begin
              bit_q <= bit_q - 3'd1;
            end
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        PEND: begin
          if (!hold_upd) begin
            cbu_q   <= trial_pu_q;
            cbd_q   <= trial_pd_q;
            upd_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trial_pu = trial_pu_q;
  assign trial_pd = trial_pd_q;
  assign cbu      = cbu_q;
  assign cbd      = cbd_q;
  assign cal_busy = busy_q;
  assign upd      = upd_q;
  assign cal_err  = err_q;

endmodule
